bus_serial_responder: RTL and testbench

Slave-side endpoint of the serial bus. It receives a selection strobe from `bus_controller`, deserialises the address and write data that the granted master shifts onto `data_bus_serial`, and performs one access on a local parallel memory port. For reads, it serialises the read data back to the master. Memory, display and interface slaves all use this block as their common bus front end, and `busy_out` feeds the arbiter's `slaves_in` vector.

---
 rtl/bus_serial_responder.sv | 145 ++++++++++++++
 tb/tb_bus_serial_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_serial_responder.sv
// Serial bus slave front end: deserialises address/write data from the open-drain
// line, issues one local memory access, and serialises read data back to the master.
module bus_serial_responder #(
    parameter int ADDRESS_WIDTH = 12,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_wrt,
    input  logic                     bus_util,
    input  logic                     arbiter_cmd_in,
    output logic                     busy_out,
    inout  wire                      data_bus_serial,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic                     mem_we,
    output logic                     mem_re,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    localparam int MAX_WIDTH = (ADDRESS_WIDTH > DATA_WIDTH) ? ADDRESS_WIDTH : DATA_WIDTH;
    localparam int CNT_WIDTH = $clog2(MAX_WIDTH) + 1;
    localparam logic [CNT_WIDTH-1:0] ADDR_LAST = CNT_WIDTH'(ADDRESS_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] DATA_LAST = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        WSTB,
        RSTB,
        RCAP,
        RDATA
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [CNT_WIDTH-1:0]   bit_cnt;
    logic                   is_write;
    logic [DATA_WIDTH-1:0]  rdata_shift;
    logic                   drive_low;
    logic                   bus_bit;

    // Open-drain: only ever pull the line low, the pull-up supplies a 1.
    assign data_bus_serial = drive_low ? 1'b0 : 1'bz;
    assign bus_bit         = data_bus_serial;

    // Next-state and strobe decode; a high bus_util in any active state aborts
    // the transaction and suppresses the strobe of that cycle.
    always_comb begin
        next_state = state;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        drive_low  = 1'b0;
        case (state)
            IDLE: begin
                if (arbiter_cmd_in && !bus_util) begin
                    next_state = ADDR;
                end
            end
            ADDR: begin
                if (bus_util) begin
                    next_state = IDLE;
                end else if (bit_cnt == ADDR_LAST) begin
                    next_state = is_write ? WDATA : RSTB;
                end
            end
            WDATA: begin
                if (bus_util) begin
                    next_state = IDLE;
                end else if (bit_cnt == DATA_LAST) begin
                    next_state = WSTB;
                end
            end
            WSTB: begin
                mem_we     = !bus_util;
                next_state = IDLE;
            end
            RSTB: begin
                mem_re     = !bus_util;
                next_state = bus_util ? IDLE : RCAP;
            end
            RCAP: begin
                next_state = bus_util ? IDLE : RDATA;
            end
            RDATA: begin
                drive_low = !rdata_shift[0];
                if (bus_util || (bit_cnt == DATA_LAST)) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register plus the datapath that each state advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy_out    <= 1'b0;
            bit_cnt     <= '0;
            is_write    <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rdata_shift <= '0;
        end else begin
            state    <= next_state;
            busy_out <= (next_state != IDLE);
            case (state)
                IDLE: begin
                    if (next_state == ADDR) begin
                        is_write <= rd_wrt;
                        bit_cnt  <= '0;
                    end
                end
                ADDR: begin
                    if (!bus_util) begin
                        mem_addr <= {bus_bit, mem_addr[ADDRESS_WIDTH-1:1]};
                        bit_cnt  <= (bit_cnt == ADDR_LAST) ? '0 : bit_cnt + CNT_ONE;
                    end
                end
                WDATA: begin
                    if (!bus_util) begin
                        mem_wdata <= {bus_bit, mem_wdata[DATA_WIDTH-1:1]};
                        bit_cnt   <= bit_cnt + CNT_ONE;
                    end
                end
                RCAP: begin
                    rdata_shift <= mem_rdata;
                    bit_cnt     <= '0;
                end
                RDATA: begin
                    rdata_shift <= rdata_shift >> 1;
                    bit_cnt     <= bit_cnt + CNT_ONE;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_serial_responder.sv
// Directed bench for bus_serial_responder: plays the master on the open-drain line,
// checks strobes, busy and the serial read data cycle by cycle against hand-worked values.
module tb_bus_serial_responder;

    logic        clk;
    logic        rst;
    logic        rd_wrt;
    logic        bus_util;
    logic        arbiter_cmd_in;
    logic        busy_out;
    wire         data_bus_serial;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;
    logic        m_drive_low;

    int pass_count;
    int check_count;

    pullup (data_bus_serial);
    assign data_bus_serial = m_drive_low ? 1'b0 : 1'bz;

    bus_serial_responder #(
        .ADDRESS_WIDTH(12),
        .DATA_WIDTH   (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rd_wrt         (rd_wrt),
        .bus_util       (bus_util),
        .arbiter_cmd_in (arbiter_cmd_in),
        .busy_out       (busy_out),
        .data_bus_serial(data_bus_serial),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_we         (mem_we),
        .mem_re         (mem_re),
        .mem_rdata      (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic cmd, input logic util, input logic rw);
        arbiter_cmd_in = cmd;
        bus_util       = util;
        rd_wrt         = rw;
    endtask

    // Called at the T0 negedge with the DUT idle; returns at the T22 negedge.
    task automatic doWrite(input logic [11:0] addr, input logic [7:0] data, input int strobe_at);
        logic busy_all;
        logic we_seen;
        busy_all = 1'b1;
        we_seen  = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int t = 1; t <= 20; t++) begin
            busy_all = busy_all & busy_out;
            we_seen  = we_seen | mem_we;
            m_drive_low    = (t <= 12) ? !addr[t-1] : !data[t-13];
            arbiter_cmd_in = (t == strobe_at);
            @(negedge clk);
        end
        m_drive_low    = 1'b0;
        arbiter_cmd_in = 1'b0;
        checkOutput("wr_busy_t1_t20", 32'(busy_all), 32'd1);
        checkOutput("wr_we_early", 32'(we_seen), 32'd0);
        checkOutput("wr_we_t21", 32'(mem_we), 32'd1);
        checkOutput("wr_busy_t21", 32'(busy_out), 32'd1);
        checkOutput("wr_addr", 32'(mem_addr), 32'(addr));
        checkOutput("wr_wdata", 32'(mem_wdata), 32'(data));
        @(negedge clk);
        checkOutput("wr_we_t22", 32'(mem_we), 32'd0);
        checkOutput("wr_busy_t22", 32'(busy_out), 32'd0);
    endtask

    // Called at the T0 negedge with the DUT idle; returns at the T23 negedge.
    task automatic doRead(input logic [11:0] addr, input logic [7:0] rdata);
        logic busy_all;
        logic re_seen;
        busy_all = 1'b1;
        re_seen  = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int t = 1; t <= 12; t++) begin
            busy_all    = busy_all & busy_out;
            re_seen     = re_seen | mem_re | mem_we;
            m_drive_low = !addr[t-1];
            @(negedge clk);
        end
        m_drive_low = 1'b0;
        checkOutput("rd_busy_t1_t12", 32'(busy_all), 32'd1);
        checkOutput("rd_strobe_early", 32'(re_seen), 32'd0);
        checkOutput("rd_re_t13", 32'(mem_re), 32'd1);
        mem_rdata = ~rdata;
        @(negedge clk);
        checkOutput("rd_re_t14", 32'(mem_re), 32'd0);
        checkOutput("rd_turn_line", 32'(data_bus_serial), 32'd1);
        mem_rdata = rdata;
        @(negedge clk);
        mem_rdata = ~rdata;
        for (int j = 0; j < 8; j++) begin
            checkOutput($sformatf("rd_bit%0d", j), 32'(data_bus_serial), 32'(rdata[j]));
            busy_all = busy_all & busy_out;
            @(negedge clk);
        end
        checkOutput("rd_busy_t15_t22", 32'(busy_all), 32'd1);
        checkOutput("rd_line_t23", 32'(data_bus_serial), 32'd1);
        checkOutput("rd_busy_t23", 32'(busy_out), 32'd0);
    endtask

    initial begin
        logic [11:0] abort_addr;
        logic [11:0] rst_addr;
        logic        we_seen;
        logic        low_seen;
        logic        busy_seen;

        pass_count  = 0;
        check_count = 0;
        m_drive_low = 1'b0;
        mem_rdata   = 8'h00;
        rst         = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(busy_out), 32'd0);
        checkOutput("rst_we", 32'(mem_we), 32'd0);
        checkOutput("rst_re", 32'(mem_re), 32'd0);
        checkOutput("rst_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("rst_line", 32'(data_bus_serial), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] strobe in idle with bus busy");
        applyStimulus(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("ign_idle_busy", 32'(busy_out), 32'd0);
        @(negedge clk);
        checkOutput("ign_idle_busy2", 32'(busy_out), 32'd0);

        $display("[TB] write 0x5A5 <= 0xE7");
        doWrite(12'h5A5, 8'd231, 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);

        $display("[TB] read 0x000 -> 0x99");
        doRead(12'h000, 8'd153);
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);

        $display("[TB] abort at T5");
        abort_addr = 12'h3F3;
        applyStimulus(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int t = 1; t <= 4; t++) begin
            m_drive_low = !abort_addr[t-1];
            @(negedge clk);
        end
        m_drive_low = 1'b0;
        bus_util    = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy_t6", 32'(busy_out), 32'd0);
        we_seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            we_seen = we_seen | mem_we | busy_out;
            @(negedge clk);
        end
        checkOutput("abort_no_we", 32'(we_seen), 32'd0);

        $display("[TB] write with stray strobe at T8");
        doWrite(12'h3C1, 8'h42, 8);
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);

        $display("[TB] back-to-back write then read");
        doWrite(12'h0F0, 8'h81, 0);
        doRead(12'h123, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);

        $display("[TB] reset during read data");
        rst_addr = 12'h2AA;
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int t = 1; t <= 12; t++) begin
            m_drive_low = !rst_addr[t-1];
            @(negedge clk);
        end
        m_drive_low = 1'b0;
        @(negedge clk);
        mem_rdata = 8'h00;
        @(negedge clk);
        checkOutput("rstrd_bit0", 32'(data_bus_serial), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstrd_line_t18", 32'(data_bus_serial), 32'd1);
        checkOutput("rstrd_busy_t18", 32'(busy_out), 32'd0);
        checkOutput("rstrd_addr_t18", 32'(mem_addr), 32'd0);
        rst      = 1'b0;
        low_seen  = 1'b0;
        busy_seen = 1'b0;
        for (int t = 0; t < 8; t++) begin
            low_seen  = low_seen | !data_bus_serial;
            busy_seen = busy_seen | busy_out;
            @(negedge clk);
        end
        checkOutput("rstrd_no_drive", 32'(low_seen), 32'd0);
        checkOutput("rstrd_no_busy", 32'(busy_seen), 32'd0);

        $display("[TB] read after reset recovery");
        doRead(12'hABC, 8'h36);
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
